// File: rtl/bus_timer_pkg.sv
// Shared constants for the bus-mapped interval timer: register offsets
// within the 8-byte window and bit positions inside CTRL and STATUS.
package bus_timer_pkg;

    localparam logic [2:0] TMR_CNT_LO = 3'd0;
    localparam logic [2:0] TMR_CNT_HI = 3'd1;
    localparam logic [2:0] TMR_CTRL   = 3'd2;
    localparam logic [2:0] TMR_STATUS = 3'd3;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_CONT = 1;
    localparam int CTRL_IE   = 2;

    localparam int STATUS_FLAG = 0;

endpackage

// File: rtl/bus_timer.sv
// Interval timer responding on the 6502 bus. Every CPU bus cycle is marked
// by a phi2 falling edge; register writes, read side effects and counter
// ticks all happen on the i_clk edge that sees that fall. The 16-bit down
// counter raises FLAG on expiry and optionally drives the active-low IRQ.
module bus_timer
    import bus_timer_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR   = 16'hD000,
    parameter logic [15:0] RESET_LATCH = 16'hFFFF
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_phi2,
    input  logic        i_rw,
    input  logic [15:0] i_addr,
    input  logic [7:0]  i_data,
    output logic [7:0]  o_data,
    output logic        o_sel,
    output logic        o_irq_n
);

    logic        phi2_q;
    logic [15:0] cnt_q,   cnt_d;
    logic [15:0] latch_q, latch_d;
    logic        en_q,    en_d;
    logic        cont_q,  cont_d;
    logic        ie_q,    ie_d;
    logic        flag_q,  flag_d;
    logic        irq_n_q, irq_n_d;

    logic        fall;
    logic        wr;
    logic        rd;
    logic        hi_wr;
    logic        tick;
    logic [2:0]  off;
    logic [7:0]  rd_val;

    assign off   = i_addr[2:0];
    assign o_sel = (i_addr[15:3] == BASE_ADDR[15:3]);
    assign fall  = phi2_q & ~i_phi2;
    assign wr    = fall & o_sel & ~i_rw;
    assign rd    = fall & o_sel & i_rw;
    // A CNT_HI write reloads the counter and suppresses that event's tick.
    assign hi_wr = wr & (off == TMR_CNT_HI);
    assign tick  = fall & en_q & ~hi_wr;

    // Register read view; offsets 4-7 are unused and read zero.
    always_comb begin
        rd_val = 8'h00;
        case (off)
            TMR_CNT_LO: rd_val = cnt_q[7:0];
            TMR_CNT_HI: rd_val = cnt_q[15:8];
            TMR_CTRL:   rd_val = {5'b0, ie_q, cont_q, en_q};
            TMR_STATUS: rd_val = {7'b0, flag_q};
            default:    rd_val = 8'h00;
        endcase
    end

    assign o_data  = (o_sel & i_rw) ? rd_val : 8'h00;
    assign o_irq_n = irq_n_q;

    // Next state: bus writes and read side effects first, then the tick,
    // so an expiry (FLAG set, one-shot EN clear) wins over same-event
    // STATUS clears and CTRL writes. The tick itself uses the old EN/CONT.
    always_comb begin
        cnt_d   = cnt_q;
        latch_d = latch_q;
        en_d    = en_q;
        cont_d  = cont_q;
        ie_d    = ie_q;
        flag_d  = flag_q;

        if (wr) begin
            case (off)
                TMR_CNT_LO: latch_d[7:0] = i_data;
                TMR_CNT_HI: begin
                    latch_d[15:8] = i_data;
                    cnt_d         = {i_data, latch_q[7:0]};
                    flag_d        = 1'b0;
                end
                TMR_CTRL: begin
                    en_d   = i_data[CTRL_EN];
                    cont_d = i_data[CTRL_CONT];
                    ie_d   = i_data[CTRL_IE];
                end
                TMR_STATUS: if (i_data[STATUS_FLAG]) flag_d = 1'b0;
                default: ;
            endcase
        end

        if (rd && off == TMR_STATUS) flag_d = 1'b0;

        if (tick) begin
            if (cnt_q != 16'd0) begin
                cnt_d = cnt_q - 16'd1;
            end else begin
                flag_d = 1'b1;
                if (cont_q) cnt_d = latch_q;
                else        en_d  = 1'b0;
            end
        end

        irq_n_d = ~(flag_d & ie_d);
    end

    // State registers, including the phi2 edge-detect history.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            phi2_q  <= 1'b0;
            cnt_q   <= 16'd0;
            latch_q <= RESET_LATCH;
            en_q    <= 1'b0;
            cont_q  <= 1'b0;
            ie_q    <= 1'b0;
            flag_q  <= 1'b0;
            irq_n_q <= 1'b1;
        end else begin
            phi2_q  <= i_phi2;
            cnt_q   <= cnt_d;
            latch_q <= latch_d;
            en_q    <= en_d;
            cont_q  <= cont_d;
            ie_q    <= ie_d;
            flag_q  <= flag_d;
            irq_n_q <= irq_n_d;
        end
    end

endmodule

// File: tb/tb_bus_timer.sv
// Bench for bus_timer: a table of hand-computed bus events, a couple of
// hand-written reset sequences, then random bus traffic against a model.
module tb_bus_timer;

    logic        clk = 1'b0;
    logic        i_reset_n;
    logic        i_phi2;
    logic        i_rw;
    logic [15:0] i_addr;
    logic [7:0]  i_data;
    logic [7:0]  o_data;
    logic        o_sel;
    logic        o_irq_n;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bus_timer #(.BASE_ADDR(16'hD000), .RESET_LATCH(16'hFFFF)) dut (
        .i_clk    (clk),
        .i_reset_n(i_reset_n),
        .i_phi2   (i_phi2),
        .i_rw     (i_rw),
        .i_addr   (i_addr),
        .i_data   (i_data),
        .o_data   (o_data),
        .o_sel    (o_sel),
        .o_irq_n  (o_irq_n)
    );

    typedef struct {
        bit          rw;
        logic [15:0] addr;
        logic [7:0]  data;
        logic [7:0]  exp_rd;
        bit          exp_sel;
        bit          exp_irq_n;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // One CPU bus cycle: phi2 high for hi clocks, then low for lo clocks.
    // rd/sel are sampled just before the fall, irqn after the low phase.
    task automatic ev(input bit rw, input logic [15:0] a, input logic [7:0] d,
                      input int hi, input int lo,
                      output logic [7:0] rd, output bit sel, output bit irqn);
        i_rw = rw; i_addr = a; i_data = d; i_phi2 = 1'b1;
        repeat (hi) @(negedge clk);
        rd  = o_data;
        sel = o_sel;
        i_phi2 = 1'b0;
        @(negedge clk);
        i_rw = 1'b1; i_addr = 16'h0000; i_data = 8'h00;
        repeat (lo) @(negedge clk);
        irqn = o_irq_n;
    endtask

    task automatic do_reset();
        @(negedge clk);
        i_reset_n = 1'b0;
        i_phi2 = 1'b0; i_rw = 1'b1; i_addr = 16'h0000; i_data = 8'h00;
        repeat (2) @(negedge clk);
        i_reset_n = 1'b1;
        @(negedge clk);
    endtask

    // Behavioural reference: register contents as plain integers.
    int m_cnt, m_latch;
    bit m_en, m_cont, m_ie, m_flag;

    task automatic m_reset();
        m_cnt = 0; m_latch = 16'hFFFF;
        m_en = 0; m_cont = 0; m_ie = 0; m_flag = 0;
    endtask

    task automatic m_event(input bit rw, input logic [15:0] a, input logic [7:0] d,
                           output logic [7:0] rd, output bit sel, output bit irqn);
        int off, old_latch;
        bit inwin, hiw, ticking, old_cont;
        inwin = ((a >> 3) == (16'hD000 >> 3));
        off   = int'(a % 8);
        sel   = inwin;
        rd    = 8'h00;
        if (inwin && rw) begin
            if (off == 0)      rd = 8'(m_cnt % 256);
            else if (off == 1) rd = 8'(m_cnt / 256);
            else if (off == 2) rd = 8'(m_en + 2 * m_cont + 4 * m_ie);
            else if (off == 3) rd = 8'(m_flag);
        end
        hiw       = inwin && !rw && off == 1;
        ticking   = m_en && !hiw;
        old_cont  = m_cont;
        old_latch = m_latch;
        if (inwin && !rw) begin
            if (off == 0) m_latch = (m_latch / 256) * 256 + d;
            if (off == 1) begin
                m_latch = d * 256 + (m_latch % 256);
                m_cnt   = m_latch;
                m_flag  = 0;
            end
            if (off == 2) begin
                m_en = d[0]; m_cont = d[1]; m_ie = d[2];
            end
            if (off == 3 && d[0]) m_flag = 0;
        end
        if (inwin && rw && off == 3) m_flag = 0;
        if (ticking) begin
            if (m_cnt > 0) m_cnt = m_cnt - 1;
            else begin
                m_flag = 1;
                if (old_cont) m_cnt = old_latch;
                else          m_en = 0;
            end
        end
        irqn = !(m_flag && m_ie);
    endtask

    function automatic vec_t mk(bit rw, logic [15:0] a, logic [7:0] d, logic [7:0] r, bit irqn);
        vec_t v;
        v.rw = rw; v.addr = a; v.data = d; v.exp_rd = r;
        v.exp_sel = (a[15:3] == 13'h1A00);
        v.exp_irq_n = irqn;
        return v;
    endfunction

    initial begin
        logic [7:0] rd, erd;
        bit sel, irqn, esel, eirqn;

        i_reset_n = 1'b0;
        i_phi2 = 1'b0; i_rw = 1'b1; i_addr = 16'h0000; i_data = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_irq_n", 16'(o_irq_n), 16'h1);
        chk("rst_sel",   16'(o_sel),   16'h0);
        chk("rst_data",  16'(o_data),  16'h00);
        i_reset_n = 1'b1;
        @(negedge clk);

        // Directed table: expected values worked out by hand.
        tbl.push_back(mk(1, 16'hD001, 8'h00, 8'h00, 1));
        tbl.push_back(mk(0, 16'hD001, 8'hFF, 8'h00, 1)); // counter <= FFFF from reset latch
        tbl.push_back(mk(1, 16'hD000, 8'h00, 8'hFF, 1));
        tbl.push_back(mk(1, 16'hD001, 8'h00, 8'hFF, 1));
        tbl.push_back(mk(0, 16'hD000, 8'h03, 8'h00, 1));
        tbl.push_back(mk(0, 16'hD001, 8'h00, 8'h00, 1));
        tbl.push_back(mk(0, 16'hD002, 8'h05, 8'h00, 1)); // EN+IE one-shot
        tbl.push_back(mk(1, 16'hD000, 8'h00, 8'h03, 1));
        tbl.push_back(mk(1, 16'hD000, 8'h00, 8'h02, 1));
        tbl.push_back(mk(1, 16'hD000, 8'h00, 8'h01, 1));
        tbl.push_back(mk(1, 16'hD000, 8'h00, 8'h00, 0)); // 4th fall: expiry
        tbl.push_back(mk(1, 16'hD000, 8'h00, 8'h00, 0));
        tbl.push_back(mk(1, 16'hD002, 8'h00, 8'h04, 0)); // EN cleared
        tbl.push_back(mk(1, 16'hD003, 8'h00, 8'h01, 1)); // read clears FLAG
        tbl.push_back(mk(1, 16'hD003, 8'h00, 8'h00, 1));
        tbl.push_back(mk(0, 16'hD000, 8'h02, 8'h00, 1));
        tbl.push_back(mk(0, 16'hD001, 8'h00, 8'h00, 1));
        tbl.push_back(mk(0, 16'hD002, 8'h07, 8'h00, 1)); // continuous
        tbl.push_back(mk(1, 16'hD000, 8'h00, 8'h02, 1));
        tbl.push_back(mk(1, 16'hD000, 8'h00, 8'h01, 1));
        tbl.push_back(mk(1, 16'hD000, 8'h00, 8'h00, 0));
        tbl.push_back(mk(1, 16'hD000, 8'h00, 8'h02, 0));
        tbl.push_back(mk(1, 16'hD000, 8'h00, 8'h01, 0));
        tbl.push_back(mk(1, 16'hD000, 8'h00, 8'h00, 0));
        tbl.push_back(mk(1, 16'hD000, 8'h00, 8'h02, 0));
        tbl.push_back(mk(1, 16'hD000, 8'h00, 8'h01, 0));
        tbl.push_back(mk(1, 16'hD003, 8'h00, 8'h01, 0)); // read + expiry: FLAG kept
        tbl.push_back(mk(1, 16'hD003, 8'h00, 8'h01, 1));
        tbl.push_back(mk(0, 16'hD008, 8'h00, 8'h00, 1)); // outside window
        tbl.push_back(mk(0, 16'hCFFF, 8'h00, 8'h00, 0)); // outside; tick expires
        tbl.push_back(mk(1, 16'hD002, 8'h00, 8'h07, 0));
        tbl.push_back(mk(1, 16'hD003, 8'h00, 8'h01, 1));
        tbl.push_back(mk(0, 16'hD002, 8'h00, 8'h00, 1)); // tick on old EN, then disable
        tbl.push_back(mk(0, 16'hD000, 8'h00, 8'h00, 1));
        tbl.push_back(mk(0, 16'hD001, 8'h00, 8'h00, 1)); // latch = 0000
        tbl.push_back(mk(0, 16'hD002, 8'h07, 8'h00, 1));
        tbl.push_back(mk(1, 16'hD003, 8'h00, 8'h00, 0)); // FLAG every fall
        tbl.push_back(mk(1, 16'hD003, 8'h00, 8'h01, 0));
        tbl.push_back(mk(1, 16'hD000, 8'h00, 8'h00, 0));
        tbl.push_back(mk(0, 16'hD002, 8'h05, 8'h00, 0));
        tbl.push_back(mk(0, 16'hD002, 8'h07, 8'h00, 0)); // one-shot expiry beats EN write
        tbl.push_back(mk(1, 16'hD002, 8'h00, 8'h06, 0));
        tbl.push_back(mk(1, 16'hD006, 8'h00, 8'h00, 0));

        foreach (tbl[i]) begin
            ev(tbl[i].rw, tbl[i].addr, tbl[i].data, 1 + (i % 3), 1 + (i % 2), rd, sel, irqn);
            chk($sformatf("tbl%0d_rd", i),   16'(rd),   16'(tbl[i].exp_rd));
            chk($sformatf("tbl%0d_sel", i),  16'(sel),  16'(tbl[i].exp_sel));
            chk($sformatf("tbl%0d_irq", i),  16'(irqn), 16'(tbl[i].exp_irq_n));
        end

        // Mid-count asynchronous reset with counter=1234 and EN=1.
        ev(0, 16'hD000, 8'h34, 1, 1, rd, sel, irqn);
        ev(0, 16'hD001, 8'h12, 1, 1, rd, sel, irqn);
        ev(0, 16'hD002, 8'h01, 1, 1, rd, sel, irqn);
        i_rw = 1'b1; i_addr = 16'hD001; i_phi2 = 1'b1;
        @(negedge clk);
        chk("pre_rst_hi", 16'(o_data), 16'h12);
        #2 i_reset_n = 1'b0;
        #1 chk("arst_cnt_hi", 16'(o_data), 16'h00);
        chk("arst_irq_n", 16'(o_irq_n), 16'h1);
        i_addr = 16'hD002;
        #1 chk("arst_ctrl", 16'(o_data), 16'h00);
        @(negedge clk);
        i_reset_n = 1'b1;
        @(negedge clk);
        ev(1, 16'hD000, 8'h00, 1, 2, rd, sel, irqn);
        chk("post_rst_lo", 16'(rd), 16'h00);
        ev(1, 16'hD000, 8'h00, 2, 1, rd, sel, irqn);
        chk("post_rst_notick", 16'(rd), 16'h00);
        chk("post_rst_irq", 16'(irqn), 16'h1);
        ev(0, 16'hD001, 8'hFF, 1, 1, rd, sel, irqn);
        ev(1, 16'hD000, 8'h00, 1, 1, rd, sel, irqn);
        chk("post_rst_latch", 16'(rd), 16'hFF);

        // Random bus traffic against the reference model.
        do_reset();
        m_reset();
        for (int n = 0; n < 400; n++) begin
            int pick;
            bit rw;
            logic [15:0] a;
            logic [7:0] d;
            pick = $urandom_range(0, 11);
            if (pick < 8)       a = 16'hD000 + 16'(pick);
            else if (pick == 8) a = 16'hD008;
            else if (pick == 9) a = 16'hCFFF;
            else                a = 16'($urandom);
            rw = ($urandom_range(0, 2) != 0);
            if (a[2:1] == 2'b00 && a[15:3] == 13'h1A00) d = 8'($urandom_range(0, 4));
            else                                         d = 8'($urandom);
            ev(rw, a, d, $urandom_range(1, 4), $urandom_range(1, 4), rd, sel, irqn);
            m_event(rw, a, d, erd, esel, eirqn);
            chk($sformatf("rnd%0d_rd", n),  16'(rd),   16'(erd));
            chk($sformatf("rnd%0d_sel", n), 16'(sel),  16'(esel));
            chk($sformatf("rnd%0d_irq", n), 16'(irqn), 16'(eirqn));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
